cnt_share_ctrl: RTL and testbench

- Arbitrates one shared WIDTH-bit counter register among NREQ requesters.
- Each requester asks for one operation per transaction: increment, or load with its own value.
- Round-robin arbitration; 4-phase req/gnt/done handshake.
- Sits between requester blocks and the counter datapath; owns the counter register, its update and its wrap flag.

---
 rtl/cnt_share_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_cnt_share_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_share_ctrl.sv
// ----------------------------------------------------------------------------
// cnt_share_ctrl
//
// Purpose:
//   Shares one WIDTH-bit counter register among NREQ requesters. Each
//   requester asks for a single operation per transaction: either increment
//   the counter or load it with the requester's own value. A round-robin
//   arbiter picks one requester at a time. The handshake is 4-phase:
//   req up -> gnt up -> done up -> req down -> gnt/done down.
//   This block owns the counter register, its update and its wrap flag.
//
// Ports:
//   clock     in   1           rising-edge clock
//   reset_    in   1           asynchronous active-low reset
//   req       in   NREQ        per-requester request level
//   op_load   in   NREQ        per-requester op: 1 = load, 0 = increment
//   load_val  in   NREQ*WIDTH  per-requester load value, slice i = [i*WIDTH +: WIDTH]
//   gnt       out  NREQ        registered one-hot grant, 0 when idle
//   done      out  1           operation committed (high while acknowledging)
//   cnt_val   out  WIDTH       shared counter register
//   wrap      out  1           one-cycle pulse when an increment rolls over to 0
//   busy      out  1           high whenever the controller is not idle
// ----------------------------------------------------------------------------
module cnt_share_ctrl #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4
) (
    input  logic                    clock,
    input  logic                    reset_,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         op_load,
    input  logic [NREQ*WIDTH-1:0]   load_val,
    output logic [NREQ-1:0]         gnt,
    output logic                    done,
    output logic [WIDTH-1:0]        cnt_val,
    output logic                    wrap,
    output logic                    busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_e;

    state_e            state_q,  state_d;
    logic [NREQ-1:0]   gnt_q,    gnt_d;
    logic              done_q,   done_d;
    logic [WIDTH-1:0]  cnt_q,    cnt_d;
    logic              wrap_q,   wrap_d;
    logic              busy_q,   busy_d;
    logic [IW-1:0]     last_q,   last_d;
    logic [IW-1:0]     win_q,    win_d;

    // Arbiter signals
    logic [NREQ-1:0]   hiMask;
    logic [NREQ-1:0]   hiReq;
    logic [IW-1:0]     hiWin;
    logic [IW-1:0]     anyWin;
    logic [IW-1:0]     arbWin;

    // Winner-selected inputs
    logic              reqWin;
    logic              loadWin;
    logic [WIDTH-1:0]  valWin;

    // Round-robin search starting just above the last winner. Requests with
    // an index above last_q get first pick; if none, the search wraps around
    // and the lowest set request wins. The descending loops leave the lowest
    // set index in hiWin/anyWin.
    always_comb begin
        hiMask = '0;
        for (int i = 0; i < NREQ; i++) begin
            hiMask[i] = (IW'(i) > last_q);
        end
        hiReq  = req & hiMask;
        hiWin  = '0;
        anyWin = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (hiReq[i]) begin
                hiWin = IW'(i);
            end
            if (req[i]) begin
                anyWin = IW'(i);
            end
        end
        arbWin = (|hiReq) ? hiWin : anyWin;
    end

    // Pick out the latched winner's request, opcode and load value. Written
    // as an explicit mux so it stays correct when NREQ is not a power of two.
    always_comb begin
        reqWin  = 1'b0;
        loadWin = 1'b0;
        valWin  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_q == IW'(i)) begin
                reqWin  = req[i];
                loadWin = op_load[i];
                valWin  = load_val[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and registered-output logic. wrap defaults to 0 so it can
    // only ever be high for the single cycle after EXEC. busy is derived from
    // the next state so that it is itself a register output.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        last_d  = last_q;
        win_d   = win_q;

        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    win_d   = arbWin;
                    gnt_d   = '0;
                    gnt_d[arbWin] = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                // Commits regardless of whether the winner's req already fell.
                if (loadWin) begin
                    cnt_d = valWin;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    wrap_d = &cnt_q;
                end
                done_d  = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                if (!reqWin) begin
                    gnt_d   = '0;
                    done_d  = 1'b0;
                    last_d  = win_q;
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset leaves last pointing at the top
    // requester so requester 0 has first priority afterwards.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= IW'(NREQ - 1);
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
            win_q   <= win_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign cnt_val = cnt_q;
    assign wrap    = wrap_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_cnt_share_ctrl.sv
// ----------------------------------------------------------------------------
// tb_cnt_share_ctrl
//
// Purpose:
//   Self-checking bench for cnt_share_ctrl. A table of whole transactions,
//   hand-written multi-cycle sequences (early drop, async reset mid-ACK,
//   priority after reset, continuous round-robin), then randomized traffic
//   checked against a transaction-level model of the arbiter and counter.
//
// Ports: none (top-level bench).
// ----------------------------------------------------------------------------
module tb_cnt_share_ctrl;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;

    logic                   clock    = 1'b0;
    logic                   reset_   = 1'b0;
    logic [NREQ-1:0]        req      = '0;
    logic [NREQ-1:0]        op_load  = '0;
    logic [NREQ*WIDTH-1:0]  load_val = '0;
    logic [NREQ-1:0]        gnt;
    logic                   done;
    logic [WIDTH-1:0]       cnt_val;
    logic                   wrap;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NREQ-1:0]       reqM;
        logic [NREQ-1:0]       opl;
        logic [NREQ*WIDTH-1:0] lv;
        logic [NREQ-1:0]       expGnt;
        logic [WIDTH-1:0]      expCnt;
        logic                  expWrap;
    } vec_t;

    vec_t tbl[12];

    // Transaction-level model state for the random phase
    int               mLast;
    int               mCnt;
    bit               pend[NREQ];
    bit               mOp[NREQ];
    logic [WIDTH-1:0] mVal[NREQ];
    int               waitCnt[NREQ];

    cnt_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clock    (clock),
        .reset_   (reset_),
        .req      (req),
        .op_load  (op_load),
        .load_val (load_val),
        .gnt      (gnt),
        .done     (done),
        .cnt_val  (cnt_val),
        .wrap     (wrap),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    // Hard time limit so the bench always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic doReset;
        reset_   = 1'b0;
        req      = '0;
        op_load  = '0;
        load_val = '0;
        repeat (2) @(posedge clock);
        #1;
        reset_ = 1'b1;
    endtask

    // One full transaction: grant, execute, one held ACK cycle, release
    task automatic applyStimulus(input vec_t v, input string tag);
        req      = v.reqM;
        op_load  = v.opl;
        load_val = v.lv;
        tick;
        checkOutput({tag, ".gnt"},   32'(gnt),  32'(v.expGnt));
        checkOutput({tag, ".busy"},  32'(busy), 32'd1);
        checkOutput({tag, ".done0"}, 32'(done), 32'd0);
        tick;
        checkOutput({tag, ".done"},  32'(done),    32'd1);
        checkOutput({tag, ".cnt"},   32'(cnt_val), 32'(v.expCnt));
        checkOutput({tag, ".wrap"},  32'(wrap),    32'(v.expWrap));
        tick;
        checkOutput({tag, ".wrapclr"}, 32'(wrap), 32'd0);
        checkOutput({tag, ".hold"},    32'(gnt),  32'(v.expGnt));
        req = '0;
        tick;
        checkOutput({tag, ".relgnt"},  32'(gnt),  32'd0);
        checkOutput({tag, ".reldone"}, 32'(done), 32'd0);
        checkOutput({tag, ".relbusy"}, 32'(busy), 32'd0);
    endtask

    task automatic driveFromModel;
        for (int i = 0; i < NREQ; i++) begin
            req[i]     = pend[i];
            op_load[i] = mOp[i];
            load_val[i*WIDTH +: WIDTH] = mVal[i];
        end
    endtask

    task automatic raise(input int i);
        pend[i]    = 1'b1;
        mOp[i]     = ($urandom_range(0, 3) == 0);
        mVal[i]    = WIDTH'($urandom);
        waitCnt[i] = 0;
    endtask

    initial begin
        logic [NREQ-1:0] eg;
        int              win;
        int              expCnt;
        bit              expWrap;
        bit              anyP;
        vec_t            v;

        // ---------------- reset values ----------------
        doReset;
        checkOutput("rst.gnt",  32'(gnt),     32'd0);
        checkOutput("rst.done", 32'(done),    32'd0);
        checkOutput("rst.cnt",  32'(cnt_val), 32'd0);
        checkOutput("rst.wrap", 32'(wrap),    32'd0);
        checkOutput("rst.busy", 32'(busy),    32'd0);

        // ---------------- table-driven transactions ----------------
        // Round-robin pointer starts at 3, counter at 0.
        tbl[0]  = '{4'b0100, 4'b0000, 16'h0000, 4'b0100, 4'h1, 1'b0};
        tbl[1]  = '{4'b0001, 4'b0001, 16'h000F, 4'b0001, 4'hF, 1'b0};
        tbl[2]  = '{4'b0010, 4'b0000, 16'h0000, 4'b0010, 4'h0, 1'b1};
        tbl[3]  = '{4'b1010, 4'b1000, 16'h5000, 4'b1000, 4'h5, 1'b0};
        tbl[4]  = '{4'b1010, 4'b0000, 16'h0000, 4'b0010, 4'h6, 1'b0};
        tbl[5]  = '{4'b1111, 4'b0100, 16'h0A00, 4'b0100, 4'hA, 1'b0};
        tbl[6]  = '{4'b0011, 4'b0011, 16'h00C3, 4'b0001, 4'h3, 1'b0};
        tbl[7]  = '{4'b0011, 4'b0011, 16'h00C3, 4'b0010, 4'hC, 1'b0};
        tbl[8]  = '{4'b1111, 4'b0000, 16'h0000, 4'b0100, 4'hD, 1'b0};
        tbl[9]  = '{4'b1001, 4'b0000, 16'h0000, 4'b1000, 4'hE, 1'b0};
        tbl[10] = '{4'b1001, 4'b0000, 16'h0000, 4'b0001, 4'hF, 1'b0};
        tbl[11] = '{4'b1001, 4'b0000, 16'h0000, 4'b1000, 4'h0, 1'b1};
        for (int i = 0; i < 12; i++) begin
            applyStimulus(tbl[i], $sformatf("vec%0d", i));
        end

        // ---------------- early drop during EXEC ----------------
        // Requester 1 loads 5 (pointer becomes 1), then requester 3 drops
        // its req while its increment is executing.
        v = '{4'b0010, 4'b0010, 16'h0050, 4'b0010, 4'h5, 1'b0};
        applyStimulus(v, "edLoad");
        req = 4'b1000; op_load = '0; load_val = '0;
        tick;
        checkOutput("ed.gnt", 32'(gnt), 32'h8);
        req = '0;
        tick;
        checkOutput("ed.cnt",  32'(cnt_val), 32'h6);
        checkOutput("ed.done", 32'(done),    32'd1);
        tick;
        checkOutput("ed.rel",  32'(gnt),  32'd0);
        checkOutput("ed.busy", 32'(busy), 32'd0);
        req = 4'b1011;
        tick;
        checkOutput("ed.next", 32'(gnt), 32'h1);
        req = '0;
        tick;
        tick;

        // ---------------- async reset mid-ACK ----------------
        doReset;
        req = 4'b0010; op_load = 4'b0010; load_val = 16'h0090;
        tick;
        tick;
        checkOutput("ar.cnt9", 32'(cnt_val), 32'h9);
        req = 4'b0011;
        #2;
        reset_ = 1'b0;
        #1;
        checkOutput("ar.gnt",  32'(gnt),     32'd0);
        checkOutput("ar.done", 32'(done),    32'd0);
        checkOutput("ar.cnt",  32'(cnt_val), 32'd0);
        checkOutput("ar.wrap", 32'(wrap),    32'd0);
        checkOutput("ar.busy", 32'(busy),    32'd0);
        tick;
        tick;
        checkOutput("ar.ignored", 32'(gnt), 32'd0);
        reset_ = 1'b1; op_load = '0;
        tick;
        checkOutput("ar.first", 32'(gnt), 32'h1);
        req = '0;
        tick;
        checkOutput("ar.inc", 32'(cnt_val), 32'h1);
        tick;

        // ---------------- priority after reset ----------------
        doReset;
        req = 4'b1010;
        tick;
        checkOutput("pr.first", 32'(gnt), 32'h2);
        tick;
        req = 4'b1000;
        tick;
        checkOutput("pr.rel", 32'(gnt), 32'd0);
        req = 4'b1010;
        tick;
        checkOutput("pr.second", 32'(gnt), 32'h8);
        req = '0;
        tick;
        tick;

        // ---------------- continuous round-robin ----------------
        doReset;
        for (int t = 0; t < 5; t++) begin
            req = 4'b1111;
            tick;
            eg = '0;
            eg[t % NREQ] = 1'b1;
            checkOutput($sformatf("rr%0d.gnt", t), 32'(gnt), 32'(eg));
            tick;
            checkOutput($sformatf("rr%0d.done", t), 32'(done), 32'd1);
            req = req & ~eg;
            tick;
            checkOutput($sformatf("rr%0d.rel", t), 32'(gnt), 32'd0);
        end
        req = '0;
        tick;

        // ---------------- randomized traffic vs model ----------------
        doReset;
        mLast = NREQ - 1;
        mCnt  = 0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i]    = 1'b0;
            mOp[i]     = 1'b0;
            mVal[i]    = '0;
            waitCnt[i] = 0;
        end
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) raise(i);
            end
            anyP = 1'b0;
            for (int i = 0; i < NREQ; i++) anyP |= pend[i];
            if (!anyP) raise($urandom_range(0, NREQ - 1));
            driveFromModel;

            win = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (win < 0 && pend[(mLast + k) % NREQ]) win = (mLast + k) % NREQ;
            end
            if (mOp[win]) begin
                expCnt  = int'(mVal[win]);
                expWrap = 1'b0;
            end else begin
                expWrap = (mCnt == (1 << WIDTH) - 1);
                expCnt  = (mCnt + 1) % (1 << WIDTH);
            end
            eg = '0;
            eg[win] = 1'b1;

            tick;
            checkOutput($sformatf("rnd%0d.gnt", n),  32'(gnt),  32'(eg));
            checkOutput($sformatf("rnd%0d.busy", n), 32'(busy), 32'd1);
            checkOutput($sformatf("rnd%0d.fair", n), 32'(waitCnt[win] < NREQ), 32'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (i != win && pend[i]) waitCnt[i]++;
            end
            tick;
            checkOutput($sformatf("rnd%0d.cnt", n),  32'(cnt_val), 32'(expCnt));
            checkOutput($sformatf("rnd%0d.done", n), 32'(done),    32'd1);
            checkOutput($sformatf("rnd%0d.wrap", n), 32'(wrap),    32'(expWrap));
            mCnt = expCnt;
            repeat ($urandom_range(0, 2)) begin
                tick;
                checkOutput($sformatf("rnd%0d.hold", n), 32'(gnt),  32'(eg));
                checkOutput($sformatf("rnd%0d.wclr", n), 32'(wrap), 32'd0);
            end
            pend[win] = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (i != win && !pend[i] && $urandom_range(0, 3) == 0) raise(i);
            end
            driveFromModel;
            tick;
            checkOutput($sformatf("rnd%0d.rel", n),  32'(gnt),  32'd0);
            checkOutput($sformatf("rnd%0d.idle", n), 32'(busy), 32'd0);
            mLast = win;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
